output_writeback: RTL and testbench

Drains one result tile from the output buffer back into the shared buffer at a caller-supplied base address. It is the return path to the compute controller's load path: the controller fills the weight and activation buffers from the shared buffer and runs the array into the output buffer; this block moves the output buffer contents into shared buffer space starting at OADDR. It uses a start/busy/done handshake and stalls on a shared-buffer grant.

---
 rtl/wb_pkg.sv | 7 +
 rtl/wb_skid_reg.sv | 28 ++
 rtl/output_writeback.sv | 123 ++++++++++++
 tb/tb_output_writeback.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: state encoding, memory polarity constants and address width shared by output_writeback.
package wb_pkg;
    localparam int   ADDR_W    = 13;
    localparam logic CEN_ON    = 1'b0;
    localparam logic WEN_WRITE = 1'b0;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
endpackage

// File: rtl/wb_skid_reg.sv
// wb_skid_reg: single-entry valid/data holding register; load takes priority over unload.
module wb_skid_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/output_writeback.sv
// output_writeback: drains one output-buffer tile into the shared buffer at OADDR with start/busy/done.
// Define WB_RELU_EN to clamp negative (signed) words to zero as they are captured.
module output_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] OADDR,
    input  logic              SHARE_GNT,
    output logic              BUSY,
    output logic              DONE,
    output logic              output_ren,
    output logic              output_cen,
    output logic [ADDR_W-1:0] output_addr,
    input  logic [DATA_W-1:0] output_rdata,
    output logic              share_wen,
    output logic              share_ren,
    output logic              share_cen,
    output logic [ADDR_W-1:0] share_addr,
    output logic [DATA_W-1:0] share_wdata
);
    localparam logic [ADDR_W:0] CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, raddr_q, raddr_d, saddr_q, saddr_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] slot_q, slot_d, arr_data, sk0_data, sk1_data;
    logic              ren_q, ren_d, arr_q, slot_v_q, slot_v_d, busy_q, done_q;
    logic              sk0_v, sk1_v, sk0_load, sk1_load, slot_load, shift, start, issue;
    logic [2:0]        occ;

`ifdef WB_RELU_EN
    assign arr_data = output_rdata[DATA_W-1] ? '0 : output_rdata;
`else
    assign arr_data = output_rdata;
`endif

    // Two skid entries absorb the two reads already committed when a grant drops.
    always_comb begin
        start     = state_q == IDLE && START;
        shift     = state_q == RUN && slot_v_q && SHARE_GNT;
        occ       = 3'(slot_v_q) + 3'(sk0_v) + 3'(sk1_v) + 3'(arr_q) + 3'(ren_q);
        issue     = state_q == RUN && rd_cnt_q < CNT && occ <= 3'd2 + 3'(shift);
        state_d   = start ? RUN : (shift && wr_cnt_q == LAST) ? FIN : (state_q == FIN) ? IDLE : state_q;
        base_d    = start ? OADDR : base_q;
        ren_d     = start || issue;
        raddr_d   = start ? '0 : issue ? rd_cnt_q[ADDR_W-1:0] : raddr_q;
        rd_cnt_d  = start ? (ADDR_W+1)'(1) : rd_cnt_q + (ADDR_W+1)'(issue);
        wr_cnt_d  = start ? '0 : wr_cnt_q + (ADDR_W+1)'(shift);
        slot_load = shift ? (sk0_v || arr_q) : (!slot_v_q && arr_q);
        slot_v_d  = shift ? slot_load : (slot_v_q || arr_q);
        slot_d    = !slot_load ? slot_q : (shift && sk0_v) ? sk0_data : arr_data;
        saddr_d   = slot_load ? base_q + wr_cnt_d[ADDR_W-1:0] : saddr_q;
        sk0_load  = shift ? (sk1_v || (sk0_v && arr_q)) : (slot_v_q && !sk0_v && arr_q);
        sk1_load  = shift ? (sk1_v && arr_q) : (sk0_v && !sk1_v && arr_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            base_q   <= '0;
            raddr_q  <= '0;
            saddr_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            slot_q   <= '0;
            slot_v_q <= 1'b0;
            ren_q    <= 1'b0;
            arr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            raddr_q  <= raddr_d;
            saddr_q  <= saddr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            slot_q   <= slot_d;
            slot_v_q <= slot_v_d;
            ren_q    <= ren_d;
            arr_q    <= ren_q;
            busy_q   <= state_d == RUN;
            done_q   <= state_d == FIN;
        end
    end

    wb_skid_reg #(.DATA_W(DATA_W)) u_sk0 (
        .clk      (CLK),
        .rst      (RESET),
        .load_i   (sk0_load),
        .unload_i (shift),
        .data_i   ((shift && sk1_v) ? sk1_data : arr_data),
        .valid_o  (sk0_v),
        .data_o   (sk0_data)
    );

    wb_skid_reg #(.DATA_W(DATA_W)) u_sk1 (
        .clk      (CLK),
        .rst      (RESET),
        .load_i   (sk1_load),
        .unload_i (shift),
        .data_i   (arr_data),
        .valid_o  (sk1_v),
        .data_o   (sk1_data)
    );

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign output_ren  = ren_q;
    assign output_cen  = ren_q ? CEN_ON : ~CEN_ON;
    assign output_addr = raddr_q;
    assign share_cen   = slot_v_q ? CEN_ON : ~CEN_ON;
    assign share_wen   = slot_v_q ? WEN_WRITE : ~WEN_WRITE;
    assign share_ren   = 1'b0;
    assign share_addr  = saddr_q;
    assign share_wdata = slot_q;
endmodule

// File: tb/tb_output_writeback.sv
// tb_output_writeback: randomized self-checking bench for output_writeback against a tile-level model.
module tb_output_writeback;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1, START = 1'b0, SHARE_GNT = 1'b0;
    logic [12:0]       OADDR = '0;
    logic              BUSY, DONE, output_ren, output_cen, share_wen, share_ren, share_cen;
    logic [12:0]       output_addr, share_addr;
    logic [DATA_W-1:0] output_rdata = '0, share_wdata;

    always #5 CLK = ~CLK;

    output_writeback #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OADDR(OADDR), .SHARE_GNT(SHARE_GNT),
        .BUSY(BUSY), .DONE(DONE), .output_ren(output_ren), .output_cen(output_cen),
        .output_addr(output_addr), .output_rdata(output_rdata), .share_wen(share_wen),
        .share_ren(share_ren), .share_cen(share_cen), .share_addr(share_addr),
        .share_wdata(share_wdata)
    );

    // Output-buffer model: data valid only the cycle after a read, garbage otherwise.
    logic [DATA_W-1:0] obuf [0:8191];
    logic              rd_v = 1'b0;
    logic [12:0]       rd_a = '0;
    always @(negedge CLK) begin
        rd_v = output_ren && !output_cen;
        rd_a = output_addr;
    end
    always @(posedge CLK) output_rdata <= rd_v ? obuf[rd_a] : DATA_W'($urandom);

    int                checks = 0, errors = 0;
    bit                gnt_pat [0:511];
    logic [12:0]       wr_addr [$];
    logic [DATA_W-1:0] wr_data [$];
    int                done_cnt, done_cyc, busy_cnt, stall_bad, ren_bad;
    logic [3:0]        rst_snap;

    function automatic logic [DATA_W-1:0] ref_word(input logic [DATA_W-1:0] w);
`ifdef WB_RELU_EN
        return w[DATA_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // The slot is continuously occupied from cycle 3, so each granted cycle retires one word.
    function automatic int ref_done();
        int n = 0;
        for (int c = 3; c < 512; c++) begin
            if (gnt_pat[c]) n++;
            if (n == DEPTH) return c + 1;
        end
        return -1;
    endfunction

    task automatic fill_obuf();
        for (int i = 0; i < DEPTH; i++) obuf[i] = DATA_W'($urandom);
    endtask

    task automatic set_gnt(input int lo, input int hi, input bit rnd);
        for (int c = 0; c < 512; c++) gnt_pat[c] = rnd ? ($urandom_range(0, 3) != 0) : !(c >= lo && c <= hi);
    endtask

    task automatic drive_xfer(input logic [12:0] base, input int restart_at, input int rst_at, input int ncyc);
        logic              pres_prev = 1'b0;
        logic [12:0]       a_prev = '0;
        logic [DATA_W-1:0] d_prev = '0;
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_bad = 0; ren_bad = 0; rst_snap = 'x;
        @(posedge CLK); #1;
        START = 1'b1; OADDR = base; SHARE_GNT = gnt_pat[0];
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (cyc > 0) begin
                @(posedge CLK); #1;
                START = (cyc == restart_at);
                OADDR = 13'($urandom);
                RESET = (cyc == rst_at);
                SHARE_GNT = gnt_pat[cyc];
            end
            @(negedge CLK);
            if (rst_at >= 0 && cyc == rst_at + 1) rst_snap = {BUSY, DONE, share_cen, output_cen};
            if (share_ren) ren_bad++;
            if (!share_cen && !share_wen) begin
                if (pres_prev && (share_addr !== a_prev || share_wdata !== d_prev)) stall_bad++;
                if (SHARE_GNT) begin
                    wr_addr.push_back(share_addr);
                    wr_data.push_back(share_wdata);
                end
                pres_prev = !SHARE_GNT; a_prev = share_addr; d_prev = share_wdata;
            end else begin
                pres_prev = 1'b0;
            end
            if (BUSY) busy_cnt++;
            if (DONE) begin done_cnt++; done_cyc = cyc; end
        end
        START = 1'b0; RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; SHARE_GNT = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, output_ren, output_cen, output_addr, share_wen, share_ren, share_cen, share_addr, share_wdata}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 13'h0, 1'b1, 1'b0, 1'b1, 13'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got busy%b done%b ren%b cen%b oaddr%h wen%b sren%b scen%b saddr%h wdata%h",
                     BUSY, DONE, output_ren, output_cen, output_addr, share_wen, share_ren, share_cen, share_addr, share_wdata);
        end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < DEPTH; i++) obuf[i] = DATA_W'(i + 1);
        set_gnt(-1, -1, 1'b0);
        drive_xfer(13'h100, -1, -1, 22);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 13'(32'h100 + i) || wr_data[i] !== DATA_W'(i + 1)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h/%h want %h/%h", i, i < wr_addr.size() ? wr_addr[i] : 13'hx,
                         i < wr_data.size() ? wr_data[i] : 16'hx, 13'(32'h100 + i), DATA_W'(i + 1));
            end
        end
        checks++;
        if (done_cyc !== 19 || done_cnt !== 1) begin errors++; $display("FAIL basic_done: cycle %0d count %0d, want 19/1", done_cyc, done_cnt); end
        checks++;
        if (busy_cnt !== 18 || wr_addr.size() !== DEPTH) begin errors++; $display("FAIL basic_busy: busy %0d writes %0d, want 18/%0d", busy_cnt, wr_addr.size(), DEPTH); end
        checks++;
        if (ren_bad !== 0) begin errors++; $display("FAIL share_ren: asserted %0d cycles, want 0", ren_bad); end
    endtask

    task automatic test_stall();
        logic [12:0] base = 13'($urandom);
        fill_obuf();
        set_gnt(5, 8, 1'b0);
        drive_xfer(base, -1, -1, 26);
        checks++;
        if (done_cyc !== 23 || done_cyc !== ref_done() || done_cnt !== 1) begin errors++; $display("FAIL stall_done: cycle %0d count %0d, want 23/1", done_cyc, done_cnt); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, want 0", stall_bad); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== 13'(base + i) || wr_data[i] !== ref_word(obuf[i])) begin
                errors++;
                $display("FAIL stall_word%0d: got %h/%h want %h/%h", i, i < wr_addr.size() ? wr_addr[i] : 13'hx,
                         i < wr_data.size() ? wr_data[i] : 16'hx, 13'(base + i), ref_word(obuf[i]));
            end
        end
        checks++;
        if (wr_addr.size() !== DEPTH) begin errors++; $display("FAIL stall_count: %0d writes, want %0d", wr_addr.size(), DEPTH); end
    endtask

    task automatic test_wrap();
        fill_obuf();
        set_gnt(-1, -1, 1'b0);
        drive_xfer(13'h1FFA, -1, -1, 22);
        checks++;
        if (wr_addr.size() !== DEPTH || wr_addr[5] !== 13'h1FFF || wr_addr[6] !== 13'h0000 || wr_addr[15] !== 13'h0009) begin
            errors++;
            $display("FAIL wrap_addr: size %0d addr5 %h addr6 %h addr15 %h, want 16/1fff/0000/0009", wr_addr.size(), wr_addr[5], wr_addr[6], wr_addr[15]);
        end
        for (int i = 0; i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== ref_word(obuf[i])) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, wr_data[i], ref_word(obuf[i])); end
        end
    endtask

    task automatic test_restart();
        logic [12:0] base = 13'($urandom);
        fill_obuf();
        set_gnt(-1, -1, 1'b0);
        drive_xfer(base, 6, -1, 24);
        checks++;
        if (wr_addr.size() !== DEPTH || done_cnt !== 1 || done_cyc !== 19) begin
            errors++;
            $display("FAIL restart_ignored: writes %0d dones %0d done_cycle %0d, want %0d/1/19", wr_addr.size(), done_cnt, done_cyc, DEPTH);
        end
        checks++;
        if (wr_addr.size() > 0 && (wr_addr[DEPTH-1] !== 13'(base + DEPTH - 1) || wr_data[DEPTH-1] !== ref_word(obuf[DEPTH-1]))) begin
            errors++;
            $display("FAIL restart_last: got %h/%h want %h/%h", wr_addr[DEPTH-1], wr_data[DEPTH-1], 13'(base + DEPTH - 1), ref_word(obuf[DEPTH-1]));
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] base = 13'($urandom);
        fill_obuf();
        set_gnt(-1, -1, 1'b0);
        drive_xfer(base, -1, 8, 12);
        checks++;
        if (rst_snap !== 4'b0011 || done_cnt !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy/done/scen/ocen %b dones %0d, want 0011/0", rst_snap, done_cnt);
        end
        drive_xfer(base, -1, -1, 22);
        checks++;
        if (wr_addr.size() !== DEPTH || done_cyc !== 19) begin errors++; $display("FAIL reset_rerun: writes %0d done %0d, want %0d/19", wr_addr.size(), done_cyc, DEPTH); end
        for (int i = 0; i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 13'(base + i) || wr_data[i] !== ref_word(obuf[i])) begin
                errors++;
                $display("FAIL reset_rerun_word%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], 13'(base + i), ref_word(obuf[i]));
            end
        end
    endtask

    task automatic test_relu();
        logic [DATA_W-1:0] exp0;
`ifdef WB_RELU_EN
        exp0 = 16'h0000;
`else
        exp0 = 16'hFFFB;
`endif
        fill_obuf();
        obuf[0] = 16'hFFFB;
        obuf[1] = 16'h7FFF;
        set_gnt(-1, -1, 1'b0);
        drive_xfer(13'h0, -1, -1, 22);
        checks++;
        if (wr_data.size() < 2 || wr_data[0] !== exp0 || wr_data[1] !== 16'h7FFF) begin
            errors++;
            $display("FAIL relu_word: got %h/%h want %h/7fff", wr_data[0], wr_data[1], exp0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [12:0] base = 13'($urandom);
            int          exp_done;
            fill_obuf();
            set_gnt(0, 0, 1'b1);
            exp_done = ref_done();
            drive_xfer(base, int'($urandom_range(1, 10)), -1, exp_done + 3);
            checks++;
            if (done_cyc !== exp_done || done_cnt !== 1 || busy_cnt !== exp_done - 1 || stall_bad !== 0) begin
                errors++;
                $display("FAIL random%0d_timing: done %0d cnt %0d busy %0d unstable %0d, want %0d/1/%0d/0",
                         t, done_cyc, done_cnt, busy_cnt, stall_bad, exp_done, exp_done - 1);
            end
            checks++;
            if (wr_addr.size() !== DEPTH) begin errors++; $display("FAIL random%0d_count: %0d writes, want %0d", t, wr_addr.size(), DEPTH); end
            for (int i = 0; i < wr_addr.size(); i++) begin
                checks++;
                if (wr_addr[i] !== 13'(base + i) || wr_data[i] !== ref_word(obuf[i])) begin
                    errors++;
                    $display("FAIL random%0d_word%0d: got %h/%h want %h/%h", t, i, wr_addr[i], wr_data[i], 13'(base + i), ref_word(obuf[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_restart();
        test_reset_mid();
        test_relu();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
